data_decoder: RTL and testbench
===============================

DATA_DECODER -- requirements
Module: data_decoder

Interface
REQ-001 SHALL have parameter: NSYM, default 4, number of 2-bit symbols per output word (output width 2*NSYM).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream symbol valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a symbol this cycle.
REQ-006 SHALL have port: d1  input  1  symbol high bit.
REQ-007 SHALL have port: d0  input  1  symbol low bit.
REQ-008 SHALL have port: s  input  1  order select, sampled per symbol (0 = LSB-first, 1 = MSB-first).
REQ-009 SHALL have port: out_valid  output  1  out_data holds a complete word.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts word.
REQ-011 SHALL have port: out_data  output  2*NSYM  assembled word.
REQ-012 SHALL have port: frame_err  output  1  one-cycle pulse on order-select violation.

Function
REQ-013 SHALL accept a symbol only on the cycle in_valid=1 and in_ready=1.
REQ-014 SHALL implement states IDLE (count=0), COLLECT (0<count<NSYM), FULL (word held, out_valid=1).
REQ-015 SHALL drive in_ready=1 in IDLE and COLLECT; in FULL, in_ready SHALL equal out_ready.
REQ-016 SHALL latch s into an internal mode bit on the first symbol of each frame.
REQ-017 SHALL place symbol k (k=0 first), with d1 as the upper bit, at out_data[2k+1:2k] when mode=0, and at out_data[2(NSYM-1-k)+1:2(NSYM-1-k)] when mode=1.
REQ-018 SHALL transition from IDLE to COLLECT on an accepted symbol; with NSYM=1 it SHALL go directly to FULL.
REQ-019 SHALL transition to FULL on the NSYM-th accepted symbol, with out_valid=1 and the complete word on out_data on the following cycle (latency 1 cycle after the last symbol).
REQ-020 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, in FULL with out_ready=1, complete the output handshake and leave FULL.
REQ-022 SHALL, if in_valid=1 on the same cycle as REQ-021, accept that symbol as symbol 0 of the next frame, going to COLLECT (or FULL if NSYM=1).
REQ-023 SHALL, if in FULL with out_ready=1 and in_valid=0, go to IDLE with out_valid=0 the next cycle.
REQ-024 SHALL, on an accepted symbol in COLLECT whose s differs from the latched mode, discard the partial word and pulse frame_err=1 for exactly one cycle (the next cycle).
REQ-025 SHALL, in the REQ-024 case, treat the offending symbol as symbol 0 of a new frame, with mode equal to its s.
REQ-026 SHALL keep frame_err=0 at all other times; an order violation SHALL never produce out_valid.
REQ-027 SHALL ignore d1, d0 and s on cycles with no accepted symbol.

Reset
REQ-028 SHALL, on a clock edge with reset=1, set state IDLE, count 0, mode 0, out_valid 0, out_data 0 and frame_err 0.
REQ-029 SHALL drive in_ready=0 while reset=1.
REQ-030 SHALL discard any partial or held word when reset is asserted mid-operation, with no out_valid afterwards for that word.
REQ-031 SHALL give reset priority over any simultaneous input or output handshake.

Verification (NSYM=4)
REQ-032 SHALL cover: s=0, symbols d1d0 = 01,10,11,00 on consecutive cycles with out_ready=1 -> out_data=0x39 with out_valid high 1 cycle after the 4th symbol.
REQ-033 SHALL cover: same symbols with s=1 -> out_data=0x6C.
REQ-034 SHALL cover: word completed with out_ready=0 for 5 cycles -> in_ready=0, out_data held at the same value, extra in_valid ignored; then out_ready=1 with in_valid=1 -> handshake occurs and that symbol becomes symbol 0 of the next word.
REQ-035 SHALL cover: s=0 for 2 symbols, then symbol 11 with s=1 -> frame_err pulses 1 cycle and no out_valid; then 3 more symbols 00,00,01 with s=1 -> out_data=0xC1.
REQ-036 SHALL cover: reset asserted for 1 cycle after 3 symbols -> out_valid=0 and count=0; then 4 fresh symbols of 10 with s=0 -> out_data=0xAA with no residue from before the reset.
REQ-037 SHALL cover: the 4 symbols of REQ-032 with 1-3 idle cycles between each -> out_data=0x39.

Source files
------------

// File: rtl/data_decoder.sv
// Symbol-to-word assembler: packs NSYM 2-bit symbols into one word,
// LSB-first or MSB-first as chosen by the first symbol of each frame.
module data_decoder #(
    parameter int NSYM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              d1,
    input  logic              d0,
    input  logic              s,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*NSYM-1:0] out_data,
    output logic              frame_err
);

    localparam int KW = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSYM - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [1:0]        r_state;
    logic [KW-1:0]     r_count;
    logic              r_mode;
    logic [2*NSYM-1:0] r_data;
    logic              r_frame_err;

    logic              w_accept;
    logic              w_viol;
    logic              w_first;
    logic              w_mode;
    logic [KW-1:0]     w_k;
    logic [KW-1:0]     w_pos;
    logic              w_last;
    logic [2*NSYM-1:0] w_data;

    // In FULL a new symbol can only enter alongside the output handshake.
    assign in_ready  = !reset && ((r_state != ST_FULL) || out_ready);
    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign frame_err = r_frame_err;

    // Work out where the incoming symbol lands and whether it opens a frame.
    always_comb begin
        w_accept = in_valid && in_ready;
        w_viol   = w_accept && (r_state == ST_COLLECT) && (s != r_mode);
        w_first  = w_accept && ((r_state != ST_COLLECT) || w_viol);
        w_mode   = w_first ? s : r_mode;
        w_k      = w_first ? '0 : r_count;
        w_pos    = w_mode ? (K_LAST - w_k) : w_k;
        w_last   = (w_k == K_LAST);
        w_data   = w_first ? '0 : r_data;
        for (int i = 0; i < NSYM; i++) begin
            if (w_pos == KW'(i)) begin
                w_data[2*i +: 2] = {d1, d0};
            end
        end
    end

    // Frame state, symbol count, order mode, word and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_mode      <= 1'b0;
            r_data      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_viol;
            if (w_accept) begin
                r_mode <= w_mode;
                r_data <= w_data;
                if (w_last) begin
                    r_state <= ST_FULL;
                    r_count <= '0;
                end else begin
                    r_state <= ST_COLLECT;
                    r_count <= w_k + KW'(1);
                end
            end else if ((r_state == ST_FULL) && out_ready) begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_data_decoder.sv
// Directed bench for data_decoder with NSYM=4.
// Inputs change 1ns after the rising edge, outputs are sampled there too.
module tb_data_decoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       d1;
    logic       d0;
    logic       s;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       frame_err;

    int n_chk;
    int n_pass;

    data_decoder #(.NSYM(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d1        (d1),
        .d0        (d0),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted symbol; state is sampled just after the edge.
    task automatic sym(input logic [1:0] d, input logic sv);
        in_valid = 1'b1;
        {d1, d0} = d;
        s = sv;
        tick();
        in_valid = 1'b0;
    endtask

    logic [1:0] pat [4];

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        d1 = 1'b0;
        d0 = 1'b0;
        s = 1'b0;
        out_ready = 1'b1;
        pat[0] = 2'b01;
        pat[1] = 2'b10;
        pat[2] = 2'b11;
        pat[3] = 2'b00;

        tick();
        tick();
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_odata", 32'(out_data), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_iready", 32'(in_ready), 0);
        reset = 1'b0;
        #1;
        chk("idle_iready", 32'(in_ready), 1);

        // LSB-first word
        for (int i = 0; i < 4; i++) begin
            sym(pat[i], 1'b0);
            if (i < 3) chk("lsb_early", 32'(out_valid), 0);
        end
        chk("lsb_ovalid", 32'(out_valid), 1);
        chk("lsb_data", 32'(out_data), 32'h39);
        tick();
        chk("lsb_drop", 32'(out_valid), 0);

        // MSB-first word
        for (int i = 0; i < 4; i++) sym(pat[i], 1'b1);
        chk("msb_ovalid", 32'(out_valid), 1);
        chk("msb_data", 32'(out_data), 32'h6C);
        tick();
        chk("msb_drop", 32'(out_valid), 0);

        // Backpressure: word held, extra symbols ignored
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) sym(pat[i], 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            {d1, d0} = 2'b11;
            s = 1'b1;
            #1;
            chk("bp_iready", 32'(in_ready), 0);
            tick();
            chk("bp_ovalid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'h39);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ir", 32'(in_ready), 1);
        sym(2'b10, 1'b0);
        chk("bp_hs_ovalid", 32'(out_valid), 0);
        chk("bp_hs_data", 32'(out_data), 32'h02);
        sym(2'b01, 1'b0);
        sym(2'b01, 1'b0);
        chk("bp_next_early", 32'(out_valid), 0);
        sym(2'b01, 1'b0);
        chk("bp_next_ovalid", 32'(out_valid), 1);
        chk("bp_next_data", 32'(out_data), 32'h56);
        tick();

        // Order violation restarts the frame
        sym(2'b01, 1'b0);
        sym(2'b10, 1'b0);
        chk("viol_pre_ferr", 32'(frame_err), 0);
        sym(2'b11, 1'b1);
        chk("viol_ferr", 32'(frame_err), 1);
        chk("viol_ovalid", 32'(out_valid), 0);
        sym(2'b00, 1'b1);
        chk("viol_ferr_off", 32'(frame_err), 0);
        chk("viol_ovalid2", 32'(out_valid), 0);
        sym(2'b00, 1'b1);
        chk("viol_ovalid3", 32'(out_valid), 0);
        sym(2'b01, 1'b1);
        chk("viol_ovalid4", 32'(out_valid), 1);
        chk("viol_data", 32'(out_data), 32'hC1);
        chk("viol_ferr_end", 32'(frame_err), 0);
        tick();

        // Reset mid-frame, with a symbol offered during reset
        for (int i = 0; i < 3; i++) sym(2'b11, 1'b1);
        reset = 1'b1;
        in_valid = 1'b1;
        {d1, d0} = 2'b11;
        s = 1'b1;
        #1;
        chk("mrst_iready", 32'(in_ready), 0);
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("mrst_ovalid", 32'(out_valid), 0);
        chk("mrst_data", 32'(out_data), 0);
        for (int i = 0; i < 4; i++) begin
            sym(2'b10, 1'b0);
            if (i < 3) chk("mrst_early", 32'(out_valid), 0);
        end
        chk("mrst_ovalid2", 32'(out_valid), 1);
        chk("mrst_data2", 32'(out_data), 32'hAA);
        tick();

        // Reset while a word is held
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) sym(pat[i], 1'b0);
        chk("frst_held", 32'(out_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("frst_ovalid", 32'(out_valid), 0);
        tick();
        chk("frst_ovalid2", 32'(out_valid), 0);
        out_ready = 1'b1;

        // Gaps between symbols with noise on the data lines
        for (int i = 0; i < 4; i++) begin
            sym(pat[i], 1'b0);
            if (i < 3) begin
                for (int g = 0; g <= i; g++) begin
                    {d1, d0} = 2'(g + 2);
                    s = 1'b1;
                    tick();
                    chk("gap_ovalid", 32'(out_valid), 0);
                    chk("gap_ferr", 32'(frame_err), 0);
                end
            end
        end
        chk("gap_ovalid_end", 32'(out_valid), 1);
        chk("gap_data", 32'(out_data), 32'h39);
        tick();
        chk("gap_drop", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
